// File: rtl/dac_pkg.sv
// Shared DAC datapath constants and types.
package dac_pkg;

   localparam int unsigned IN_WIDTH_DEF = 8;
   localparam int unsigned N_DEF        = 256;

   typedef logic [N_DEF-1:0]      thermo_t;
   typedef logic [IN_WIDTH_DEF-1:0] ptr_t;
   typedef logic [IN_WIDTH_DEF:0]   cnt_t;

endpackage : dac_pkg

// File: rtl/thermo_rotl.sv
// Combinational barrel rotate-left of an OUT_WIDTH-bit vector by an
// IN_WIDTH-bit amount, built as IN_WIDTH power-of-two stages.
//   din    : vector to rotate
//   amt    : rotate amount (0..OUT_WIDTH-1)
//   dout_c : din rotated left by amt (bit OUT_WIDTH-1 wraps into bit 0)
module thermo_rotl #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH = 1 << IN_WIDTH
) (
   input  logic [OUT_WIDTH-1:0] din,
   input  logic [IN_WIDTH-1:0]  amt,
   output logic [OUT_WIDTH-1:0] dout_c
);

   logic [OUT_WIDTH-1:0] stg [IN_WIDTH+1];

   assign stg[0] = din;

   // Stage k rotates by 2^k when amt[k] is set.
   for (genvar k = 0; k < IN_WIDTH; k++) begin : g_stage
      localparam int unsigned SH = 1 << k;
      assign stg[k+1] = amt[k] ? ((stg[k] << SH) | (stg[k] >> (OUT_WIDTH - SH)))
                               : stg[k];
   end

   assign dout_c = stg[IN_WIDTH];

endmodule : thermo_rotl

// File: rtl/dwa_rotator.sv
// Data-weighted-averaging rotator: captures a thermometer code, checks it for
// bubbles, rotates it by a running element pointer and registers the
// unit-element select vector. Bypass mode passes the code unrotated.
//   clk, rst_n   : clock, async active-low reset
//   thermo_valid : thermo_in valid this cycle (no backpressure)
//   thermo_in    : thermometer code
//   dwa_en       : 1 = rotate, 0 = bypass (pointer holds)
//   ptr_clr      : synchronous pointer clear, also clears code_err
//   elem_sel     : registered unit-element select
//   sel_valid    : elem_sel updated this cycle
//   ptr          : current element pointer
//   code_err     : sticky bubble flag
module dwa_rotator
   import dac_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
   parameter int unsigned OUT_WIDTH = 1 << IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 thermo_valid,
   input  logic [OUT_WIDTH-1:0] thermo_in,
   input  logic                 dwa_en,
   input  logic                 ptr_clr,
   output logic [OUT_WIDTH-1:0] elem_sel,
   output logic                 sel_valid,
   output logic [IN_WIDTH-1:0]  ptr,
   output logic                 code_err
);

   localparam int unsigned CW = IN_WIDTH + 1;

   logic [CW-1:0]        in_cnt;
   logic                 in_bubble;

   logic                 s1_valid;
   logic [OUT_WIDTH-1:0] s1_code;
   logic [CW-1:0]        s1_cnt;
   logic                 s1_bubble;

   logic [OUT_WIDTH-1:0] rot_c;

   // Popcount and bubble check of the incoming code.
   always_comb begin
      in_cnt    = '0;
      in_bubble = 1'b0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         in_cnt = in_cnt + CW'(thermo_in[i]);
      end
      for (int i = 1; i < OUT_WIDTH; i++) begin
         if (thermo_in[i] && !thermo_in[i-1]) in_bubble = 1'b1;
      end
      if (!thermo_in[0] && (|thermo_in)) in_bubble = 1'b1;
   end

   // Stage 1: capture code, count and bubble flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_code   <= '0;
         s1_cnt    <= '0;
         s1_bubble <= 1'b0;
      end else begin
         s1_valid <= thermo_valid;
         if (thermo_valid) begin
            s1_code   <= thermo_in;
            s1_cnt    <= in_cnt;
            s1_bubble <= in_bubble;
         end
      end
   end

   thermo_rotl #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_rotl (
      .din    (s1_code),
      .amt    (ptr),
      .dout_c (rot_c)
   );

   // Stage 2: rotate, advance pointer, flag bubbles. ptr_clr wins over both
   // the advance and the sticky set; the sample itself still uses the old ptr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_sel  <= '0;
         sel_valid <= 1'b0;
         ptr       <= '0;
         code_err  <= 1'b0;
      end else begin
         sel_valid <= s1_valid;
         if (s1_valid) begin
            if (s1_bubble) begin
               elem_sel <= '0;
               code_err <= 1'b1;
            end else if (dwa_en) begin
               elem_sel <= rot_c;
               // Modulo-N advance: a full-scale count leaves ptr unchanged.
               ptr      <= IN_WIDTH'(CW'(ptr) + s1_cnt);
            end else begin
               elem_sel <= s1_code;
            end
         end
         if (ptr_clr) begin
            ptr      <= '0;
            code_err <= 1'b0;
         end
      end
   end

endmodule : dwa_rotator

// File: tb/tb_dwa_rotator.sv
// Directed self-checking bench for dwa_rotator (default 8-bit pointer, 256 elements).
module tb_dwa_rotator;
   import dac_pkg::*;

   logic    clk;
   logic    rst_n;
   logic    thermo_valid;
   thermo_t thermo_in;
   logic    dwa_en;
   logic    ptr_clr;
   thermo_t elem_sel;
   logic    sel_valid;
   ptr_t    ptr;
   logic    code_err;

   int checks = 0;
   int errors = 0;

   dwa_rotator #(
      .IN_WIDTH  (IN_WIDTH_DEF),
      .OUT_WIDTH (N_DEF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .thermo_valid (thermo_valid),
      .thermo_in    (thermo_in),
      .dwa_en       (dwa_en),
      .ptr_clr      (ptr_clr),
      .elem_sel     (elem_sel),
      .sel_valid    (sel_valid),
      .ptr          (ptr),
      .code_err     (code_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic thermo_t thermo_of(input int n);
      thermo_t t;
      t = '0;
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      return t;
   endfunction

   // One isolated sample; returns at the negedge after its result is registered.
   task automatic xfer(input string tag, input thermo_t code, input thermo_t exp_sel,
                       input int exp_ptr, input logic exp_err);
      @(negedge clk);
      thermo_valid = 1'b1;
      thermo_in    = code;
      @(negedge clk);
      thermo_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_vld"}, 256'(sel_valid), 256'(1));
      chk({tag, "_sel"}, elem_sel, exp_sel);
      chk({tag, "_ptr"}, 256'(ptr), 256'(exp_ptr));
      chk({tag, "_err"}, 256'(code_err), 256'(exp_err));
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      ptr_clr = 1'b1;
      @(negedge clk);
      ptr_clr = 1'b0;
   endtask

   thermo_t exp_v;

   initial begin
      rst_n        = 1'b0;
      thermo_valid = 1'b0;
      thermo_in    = '0;
      dwa_en       = 1'b1;
      ptr_clr      = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_sel", elem_sel, '0);
      chk("rst_ptr", 256'(ptr), 256'(0));
      chk("rst_vld", 256'(sel_valid), 256'(0));
      chk("rst_err", 256'(code_err), 256'(0));

      // Back-to-back tiling: 3 then 5 elements.
      @(negedge clk);
      thermo_valid = 1'b1;
      thermo_in    = thermo_t'(8'h07);
      @(negedge clk);
      thermo_in    = thermo_t'(8'h1F);
      @(negedge clk);
      thermo_valid = 1'b0;
      chk("tile0_vld", 256'(sel_valid), 256'(1));
      chk("tile0_sel", elem_sel, 256'h07);
      chk("tile0_ptr", 256'(ptr), 256'(3));
      @(negedge clk);
      chk("tile1_vld", 256'(sel_valid), 256'(1));
      chk("tile1_sel", elem_sel, 256'hF8);
      chk("tile1_ptr", 256'(ptr), 256'(8));
      @(negedge clk);
      chk("idle_vld", 256'(sel_valid), 256'(0));
      chk("idle_hold", elem_sel, 256'hF8);

      pulse_clr();
      chk("clr_ptr", 256'(ptr), 256'(0));

      // Walk ptr to 254, then wrap a count-4 code.
      xfer("w127a", thermo_of(127), thermo_of(127), 127, 1'b0);
      exp_v = thermo_of(127) << 127;
      xfer("w127b", thermo_of(127), exp_v, 254, 1'b0);
      exp_v = '0;
      exp_v[255] = 1'b1; exp_v[254] = 1'b1; exp_v[1] = 1'b1; exp_v[0] = 1'b1;
      xfer("wrap", thermo_t'(8'h0F), exp_v, 2, 1'b0);

      // Full scale and zero at ptr 77.
      exp_v = thermo_of(75) << 2;
      xfer("to77", thermo_of(75), exp_v, 77, 1'b0);
      xfer("full", '1, '1, 77, 1'b0);
      xfer("zero", '0, '0, 77, 1'b0);

      // Bubble: sticky error, pointer holds, output zeroed.
      xfer("bub", thermo_t'(8'h05), '0, 77, 1'b1);
      exp_v = '0;
      exp_v[77] = 1'b1; exp_v[78] = 1'b1;
      xfer("after_bub", thermo_t'(8'h03), exp_v, 79, 1'b1);
      pulse_clr();
      chk("bclr_ptr", 256'(ptr), 256'(0));
      chk("bclr_err", 256'(code_err), 256'(0));

      // Bypass at non-zero pointer.
      xfer("to10", thermo_of(10), thermo_of(10), 10, 1'b0);
      dwa_en = 1'b0;
      xfer("byp", thermo_t'(8'h0F), thermo_t'(8'h0F), 10, 1'b0);
      dwa_en = 1'b1;

      // ptr_clr while a count-6 sample is in stage 2: rotated by old ptr 10.
      @(negedge clk);
      thermo_valid = 1'b1;
      thermo_in    = thermo_of(6);
      @(negedge clk);
      thermo_valid = 1'b0;
      ptr_clr      = 1'b1;
      @(negedge clk);
      ptr_clr = 1'b0;
      chk("pri_vld", 256'(sel_valid), 256'(1));
      chk("pri_sel", elem_sel, 256'hFC00);
      chk("pri_ptr", 256'(ptr), 256'(0));

      // ptr_clr beats a simultaneous bubble set.
      xfer("bub2", thermo_t'(8'h05), '0, 0, 1'b1);
      @(negedge clk);
      thermo_valid = 1'b1;
      thermo_in    = thermo_t'(8'h06);
      @(negedge clk);
      thermo_valid = 1'b0;
      ptr_clr      = 1'b1;
      @(negedge clk);
      ptr_clr = 1'b0;
      chk("bpri_err", 256'(code_err), 256'(0));
      chk("bpri_sel", elem_sel, '0);

      // Mid-stream reset drops the in-flight sample.
      xfer("pre_rst", thermo_t'(8'h03), thermo_t'(8'h03), 2, 1'b0);
      @(negedge clk);
      thermo_valid = 1'b1;
      thermo_in    = thermo_t'(8'h01);
      @(negedge clk);
      thermo_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mrst_vld", 256'(sel_valid), 256'(0));
      end
      chk("mrst_sel", elem_sel, '0);
      chk("mrst_ptr", 256'(ptr), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dwa_rotator

// File: doc/dwa_rotator.md
# dwa_rotator

Data-weighted-averaging (DWA) stage that sits directly downstream of the thermometer encoder in the DAC datapath. It takes each thermometer code, rotates it by a running element pointer so the unit elements are used in cyclic order, and registers the resulting unit-element select vector for the analog array. It also checks the incoming code for bubbles and supports a bypass (no rotation) mode.

## Interface
- `IN_WIDTH`, default 8: pointer width; N = 2^IN_WIDTH.
- `OUT_WIDTH`, default 1 << IN_WIDTH: thermometer / element count N; must equal 2^IN_WIDTH.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `thermo_valid` input, 1: `thermo_in` valid this cycle. There is no backpressure.
- `thermo_in` input, OUT_WIDTH: thermometer code from the encoder.
- `dwa_en` input, 1: 1 = rotate; 0 = bypass (pass the code unrotated and hold the pointer).
- `ptr_clr` input, 1: synchronous pointer clear; also clears `code_err`.
- `elem_sel` output, OUT_WIDTH: registered unit-element select.
- `sel_valid` output, 1: `elem_sel` updated this cycle.
- `ptr` output, IN_WIDTH: current element pointer.
- `code_err` output, 1: sticky bubble flag.

## Operation
- Valid code: ones contiguous from bit 0, with zeros above them. All-zero is valid (count 0); all-ones is valid (count N).
- Bubble: any i with `thermo_in[i]`=1 and `thermo_in[i-1]`=0, or `thermo_in[0]`=0 with any bit set.
- Stage 1 (capture), on `thermo_valid`:
  - register the code, the popcount `cnt` (IN_WIDTH+1 bits, range 0..N) and the bubble flag;
  - `s1_valid` follows `thermo_valid` each cycle.
- Stage 2 (rotate), when `s1_valid`:
  - `dwa_en`=1, no bubble: `elem_sel` = rotate-left(code, `ptr`); `ptr` ← (`ptr` + `cnt`) mod N, truncating to IN_WIDTH.
  - `dwa_en`=0, no bubble: `elem_sel` = code; `ptr` holds.
  - Bubble: `elem_sel` ← 0; `ptr` holds; `code_err` ← 1 (sticky).
  - `sel_valid` = 1 in all three cases.
- `dwa_en` is sampled in stage 2 alongside the sample it applies to.
- When `s1_valid`=0: `elem_sel` holds its last value; `sel_valid`=0; `ptr` holds.
- `ptr_clr`: at the next edge `ptr` ← 0 and `code_err` ← 0.
  - It takes priority over the pointer advance and over a simultaneous bubble set.
  - A sample in stage 2 on the same cycle still rotates by the old `ptr`.
- Full scale (`cnt`=N): `elem_sel` = all ones; `ptr` is unchanged (N mod N = 0).
- Wrap-around: the rotation wraps bit N-1 into bit 0, and pointer arithmetic is modulo N.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): `elem_sel`=0, `sel_valid`=0, `ptr`=0, `code_err`=0, all stage-1 registers 0.
- Latency: 2 cycles from `thermo_valid` to `sel_valid`.
- Throughput: one code per cycle, back-to-back without bubbles in the pipeline.
- Each sample rotates by the pointer left by the previous sample; consecutive codes tile the array contiguously.
- Reset asserted mid-stream drops all in-flight samples, and no `sel_valid` follows reset release until new input arrives.
- `ptr` and `code_err` are registered outputs, updated on the same edge as `elem_sel`.

## Structure
- Shared package `dac_pkg`:
  - constants `IN_WIDTH_DEF` = 8 and `N_DEF` = 256;
  - typedefs `thermo_t` (logic [N-1:0]), `ptr_t` (logic [IN_WIDTH-1:0]) and `cnt_t` (logic [IN_WIDTH:0]).
- One sub-module, `thermo_rotl`: combinational barrel rotate-left of OUT_WIDTH bits by IN_WIDTH bits, built as log2 stages.
- The popcount and bubble check stay inline in stage 1.

## Test plan
- Reset: hold `rst_n`=0, then release -> `elem_sel`=0, `ptr`=0, `sel_valid`=0, `code_err`=0.
- Contiguous tiling, `dwa_en`=1: codes with counts 3, then 5 (0x07, 0x1F) -> `elem_sel`=0x07 with `ptr`→3, then `elem_sel`=0xF8 with `ptr`→8.
- Wrap-around, `ptr`=254: count-4 code (0xF) -> `elem_sel` bits {255, 254, 1, 0} set, `ptr`→2.
- Full scale: all-ones input, `ptr`=77 -> `elem_sel` all ones, `ptr` stays 77; then all-zero input -> `elem_sel`=0, `ptr` stays 77.
- Bubble: input 0x05 -> `elem_sel`=0, `ptr` holds, `code_err`=1 and stays 1. A later `ptr_clr` gives `ptr`=0, `code_err`=0.
- Bypass and clear priority:
  - `dwa_en`=0 with code 0x0F -> `elem_sel`=0x0F, `ptr` unchanged.
  - `ptr_clr` asserted in the same cycle a count-6 sample sits in stage 2 at `ptr`=10 -> that sample rotated by 10, `ptr`=0 afterwards.
